// File: rtl/press_count_seg.sv
`timescale 1ns/1ps
// press_count_seg
//   Counts debounced key presses as a 4-digit BCD value (0000..9999) and
//   drives a multiplexed 4-digit common-anode seven-segment display.
//
// Ports
//   i_clk    system clock (50 MHz)
//   i_rst_n  asynchronous active-low reset
//   i_flag   debounced press pulse; every high cycle counts as one press
//   i_clr    synchronous clear of count and wrap flag (wins over i_flag)
//   o_sel    digit select, active-low one-hot, bit0 = ones digit
//   o_seg    segments, active-low, bit7 = dp, bits6..0 = g..a
//   o_ovf    sticky wrap indicator (set on 9999 -> 0000)
//   o_bcd    current count {thousands, hundreds, tens, ones}
//
// Parameters
//   SCAN_DIV clock cycles per digit slot (>= 2)
//   SCAN_W   width of the scan prescaler, must hold SCAN_DIV-1
//
// Optional feature
//   LEADING_ZERO_BLANK_EN : when defined, zero digits above the most
//   significant nonzero digit are blanked; the ones digit is always shown.

module press_count_seg #(
  parameter int SCAN_DIV = 50_000,
  parameter int SCAN_W   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flag,
  input  logic        i_clr,
  output logic [3:0]  o_sel,
  output logic [7:0]  o_seg,
  output logic        o_ovf,
  output logic [15:0] o_bcd
);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [15:0]       r_bcd;
  logic              r_ovf;
  logic [SCAN_W-1:0] r_presc;
  logic [1:0]        r_idx;
  logic [3:0]        r_sel;
  logic [7:0]        r_seg;

  logic [15:0]       w_bcdInc;
  logic              w_wrap;
  logic [3:0]        w_digit;
  logic [3:0]        w_selNext;
  logic [7:0]        w_segCode;
  logic              w_blank;

  // BCD increment with the carry rippling through all four digits in one
  // cycle; w_wrap marks the 9999 -> 0000 rollover.
  always_comb begin
    w_bcdInc = r_bcd;
    w_wrap   = 1'b0;
    if (r_bcd[3:0] != 4'd9) begin
      w_bcdInc[3:0] = r_bcd[3:0] + 4'd1;
    end else begin
      w_bcdInc[3:0] = 4'd0;
      if (r_bcd[7:4] != 4'd9) begin
        w_bcdInc[7:4] = r_bcd[7:4] + 4'd1;
      end else begin
        w_bcdInc[7:4] = 4'd0;
        if (r_bcd[11:8] != 4'd9) begin
          w_bcdInc[11:8] = r_bcd[11:8] + 4'd1;
        end else begin
          w_bcdInc[11:8] = 4'd0;
          if (r_bcd[15:12] != 4'd9) begin
            w_bcdInc[15:12] = r_bcd[15:12] + 4'd1;
          end else begin
            w_bcdInc[15:12] = 4'd0;
            w_wrap          = 1'b1;
          end
        end
      end
    end
  end

  // Press counter and sticky wrap flag; clear discards a same-cycle press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bcd <= 16'h0000;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_bcd <= 16'h0000;
      r_ovf <= 1'b0;
    end else if (i_flag) begin
      r_bcd <= w_bcdInc;
      if (w_wrap) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Scan prescaler; the digit index advances once per SCAN_DIV cycles and
  // wraps 3 -> 0 naturally through its 2-bit width.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (r_presc == SCAN_LAST) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Select the nibble and the digit enable for the current scan slot.
  always_comb begin
    w_digit   = r_bcd[3:0];
    w_selNext = 4'b1110;
    case (r_idx)
      2'd0: begin w_digit = r_bcd[3:0];   w_selNext = 4'b1110; end
      2'd1: begin w_digit = r_bcd[7:4];   w_selNext = 4'b1101; end
      2'd2: begin w_digit = r_bcd[11:8];  w_selNext = 4'b1011; end
      default: begin w_digit = r_bcd[15:12]; w_selNext = 4'b0111; end
    endcase
  end

  // A digit is blanked only if it and every digit above it are zero.
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd3: w_blank = (r_bcd[15:12] == 4'd0);
      2'd2: w_blank = (r_bcd[15:8] == 8'd0);
      2'd1: w_blank = (r_bcd[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  always_comb begin
    w_blank = 1'b0;
  end
`endif

  // Active-low segment patterns, decimal point kept off.
  always_comb begin
    w_segCode = 8'hFF;
    case (w_digit)
      4'd0: w_segCode = 8'hC0;
      4'd1: w_segCode = 8'hF9;
      4'd2: w_segCode = 8'hA4;
      4'd3: w_segCode = 8'hB0;
      4'd4: w_segCode = 8'h99;
      4'd5: w_segCode = 8'h92;
      4'd6: w_segCode = 8'h82;
      4'd7: w_segCode = 8'hF8;
      4'd8: w_segCode = 8'h80;
      4'd9: w_segCode = 8'h90;
      default: w_segCode = 8'hFF;
    endcase
  end

  // Display pins are registered so they come straight from flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel <= 4'b1111;
      r_seg <= 8'hFF;
    end else begin
      r_sel <= w_selNext;
      r_seg <= w_blank ? 8'hFF : w_segCode;
    end
  end

  assign o_sel = r_sel;
  assign o_seg = r_seg;
  assign o_ovf = r_ovf;
  assign o_bcd = r_bcd;

endmodule

// File: tb/tb_press_count_seg.sv
`timescale 1ns/1ps
// tb_press_count_seg
//   Directed testbench for press_count_seg with SCAN_DIV = 4. Expected
//   values are hand-computed constants plus a small scan-position model
//   driven by the number of clock edges since reset release.

module tb_press_count_seg;

  localparam int SCAN_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  logic        clk;
  logic        rstN;
  logic        flag;
  logic        clr;
  logic [3:0]  oSel;
  logic [7:0]  oSeg;
  logic        oOvf;
  logic [15:0] oBcd;

  int checkCount = 0;
  int errorCount = 0;
  int edgeCount  = 0;

  press_count_seg #(
    .SCAN_DIV(SCAN_DIV),
    .SCAN_W  (16)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .i_flag (flag),
    .i_clr  (clr),
    .o_sel  (oSel),
    .o_seg  (oSeg),
    .o_ovf  (oOvf),
    .o_bcd  (oBcd)
  );

  // 100 MHz bench clock; the design only cares about edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one clock edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rstN) edgeCount++;
  endtask

  // Scan index the registered sel should show after edgeCount edges.
  function automatic int expIdx();
    return ((edgeCount - 1) / SCAN_DIV) % 4;
  endfunction

  function automatic logic [3:0] expSel();
    case (expIdx())
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Hold flag/clr at the given levels for a number of cycles, then idle.
  task automatic applyStimulus(input logic f, input logic c, input int cycles);
    flag = f;
    clr  = c;
    for (int i = 0; i < cycles; i++) tick();
    flag = 1'b0;
    clr  = 1'b0;
  endtask

  // Run until the model says the given digit is displayed, then check it.
  task automatic checkDigit(input int idx, input logic [7:0] expSeg,
                            input string tag);
    int n;
    n = 0;
    tick();
    while (expIdx() != idx && n < 32) begin
      tick();
      n++;
    end
    checkOutput({tag, "Sel"}, {28'd0, oSel}, {28'd0, expSel()});
    checkOutput({tag, "Seg"}, {24'd0, oSeg}, {24'd0, expSeg});
  endtask

  initial begin
    rstN = 1'b0;
    flag = 1'b0;
    clr  = 1'b0;
    #23;
    checkOutput("rstSel", {28'd0, oSel}, 32'h0000000F);
    checkOutput("rstSeg", {24'd0, oSeg}, 32'h000000FF);
    checkOutput("rstBcd", {16'd0, oBcd}, 32'h00000000);
    checkOutput("rstOvf", {31'd0, oOvf}, 32'h00000000);

    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Scan order over a little more than one full 16-cycle rotation.
    for (int i = 1; i <= 20; i++) begin
      tick();
      checkOutput("scanSel", {28'd0, oSel}, {28'd0, expSel()});
      if (i == 1) begin
        checkOutput("firstSel", {28'd0, oSel}, 32'h0000000E);
        checkOutput("firstSeg", {24'd0, oSeg}, 32'h000000C0);
      end
      if (i == 5) begin
        checkOutput("secondSel", {28'd0, oSel}, 32'h0000000D);
        checkOutput("secondSeg", {24'd0, oSeg}, 32'h000000C0);
      end
    end

    // Three separate presses.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1);
    end
    checkOutput("bcd3", {16'd0, oBcd}, 32'h00000003);
    checkDigit(0, 8'hB0, "d3i0");
    checkDigit(1, LZ, "d3i1");

    // Ten back-to-back presses: carry into the tens digit.
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("clrBcd", {16'd0, oBcd}, 32'h00000000);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("bcd10", {16'd0, oBcd}, 32'h00000010);
    checkDigit(1, 8'hF9, "d10i1");
    checkDigit(2, LZ, "d10i2");
    checkDigit(0, 8'hC0, "d10i0");

    // Full range and wrap.
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 9999);
    checkOutput("bcd9999", {16'd0, oBcd}, 32'h00009999);
    checkOutput("ovf9999", {31'd0, oOvf}, 32'h00000000);
    checkDigit(3, 8'h90, "d9999i3");
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("bcdWrap", {16'd0, oBcd}, 32'h00000000);
    checkOutput("ovfWrap", {31'd0, oOvf}, 32'h00000001);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("bcdAfterWrap", {16'd0, oBcd}, 32'h00000001);
    checkOutput("ovfSticky", {31'd0, oOvf}, 32'h00000001);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("ovfClr", {31'd0, oOvf}, 32'h00000000);
    checkOutput("bcdClr", {16'd0, oBcd}, 32'h00000000);

    // Clear wins over a same-cycle press.
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("bcd5", {16'd0, oBcd}, 32'h00000005);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("clrPriority", {16'd0, oBcd}, 32'h00000000);
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("bcd2", {16'd0, oBcd}, 32'h00000002);

    // 0042: leading zeros blanked only when the feature is built in.
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 42);
    checkOutput("bcd42", {16'd0, oBcd}, 32'h00000042);
    checkDigit(3, LZ, "d42i3");
    checkDigit(2, LZ, "d42i2");
    checkDigit(1, 8'h99, "d42i1");
    checkDigit(0, 8'hA4, "d42i0");

    // Ripple through two digits: 0099 -> 0100.
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 99);
    checkOutput("bcd99", {16'd0, oBcd}, 32'h00000099);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("bcd100", {16'd0, oBcd}, 32'h00000100);
    checkDigit(2, 8'hF9, "d100i2");
    checkDigit(1, 8'hC0, "d100i1");
    checkDigit(3, LZ, "d100i3");

    // Asynchronous reset in the middle of a scan slot while counting.
    flag = 1'b1;
    tick();
    tick();
    #2;
    rstN = 1'b0;
    edgeCount = 0;
    #1;
    checkOutput("midRstSel", {28'd0, oSel}, 32'h0000000F);
    checkOutput("midRstSeg", {24'd0, oSeg}, 32'h000000FF);
    checkOutput("midRstBcd", {16'd0, oBcd}, 32'h00000000);
    flag = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    tick();
    checkOutput("relSel", {28'd0, oSel}, 32'h0000000E);
    checkOutput("relSeg", {24'd0, oSeg}, 32'h000000C0);
    checkOutput("relBcd", {16'd0, oBcd}, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/press_count_seg.md
Name: press_count_seg

Overview:
Consumes the one-cycle press pulse from the key debounce stage and counts presses as a 4-digit BCD value from 0000 to 9999. Drives a multiplexed 4-digit common-anode seven-segment display with active-low digit select and active-low segments. Sits directly downstream of the debounce filter and feeds the board display pins.

Parameters:
SCAN_DIV, 50_000, clk cycles per digit slot (1 kHz per digit at 50 MHz); legal range is 2 or more.
SCAN_W, 16, width of the scan prescaler; must hold SCAN_DIV-1.

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
flag  input  1  debounced press pulse; each cycle it is high counts as one press
clr  input  1  synchronous count clear, active-high
sel  output  4  digit select, active-low, one-hot; bit0 = ones digit
seg  output  8  segments, active-low; bit7 = dp, bits6..0 = g..a
ovf  output  1  sticky wrap indicator
bcd  output  16  current count, {thousands, hundreds, tens, ones}

Behaviour:
- Reset (async, rst_n low):
  - bcd=16'h0000, ovf=0, sel=4'b1111, seg=8'hFF.
  - Scan prescaler=0, digit index=0.
- Counting:
  - flag=1 at a rising edge increments bcd by 1 at that edge; bcd is visible on the next cycle.
  - Each digit is counted 0..9. On a carry, the digit returns to 0 and the next digit increments; the carry ripples in the same cycle.
  - Digit values 10..15 never occur.
- Wrap: 9999 plus 1 gives 0000, and ovf goes to 1 and stays set until clr or reset.
- Clear: clr=1 sets bcd=0000 and ovf=0 at the next edge.
  - clr has priority over flag in the same cycle; that press is discarded.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it returns to 0 and the digit index advances 0→1→2→3→0.
- Outputs sel and seg are registered and are updated every cycle from the current index and bcd:
  - Index 0 gives sel=1110, index 1 gives 1101, index 2 gives 1011, index 3 gives 0111.
  - seg encodes the nibble selected by the index.
  - First cycle after reset release: sel=1110, seg=8'hC0.
  - A count change appears on seg no later than 2 cycles after the flag edge, provided that digit is currently selected.
- Segment codes (dp always off, so bit7=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- Reset mid-scan or mid-count: all state returns to the reset values immediately; no partial increment is kept.
- Consecutive flag cycles each count, so 2 back-to-back high cycles add 2.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit above the most significant nonzero digit drives seg=8'hFF while selected; sel scanning is unchanged.
  - The ones digit is never blanked, so 0000 shows as a single "0".
  - Example: bcd=0042 blanks the thousands and hundreds digits.
- Undefined: all four digits are always shown, including leading zeros.

Test Plan (SCAN_DIV=4):
- Reset, release, clock 1 cycle → sel=1110, seg=C0. After 4 more cycles → sel=1101, seg=C0. The order 1110→1101→1011→0111→1110 repeats every 16 cycles.
- 3 separate flag pulses → bcd=0003. When index=0, seg=B0.
- 10 pulses → bcd=0010. At index 1, seg=F9; at index 0, seg=C0.
- 9999 pulses → bcd=9999, ovf=0. One more pulse → bcd=0000, ovf=1. Then clr → ovf=0.
- flag and clr high in the same cycle with bcd=0005 → bcd=0000. Then flag held 2 cycles → bcd=0002.
- With LEADING_ZERO_BLANK_EN, bcd=0042 → seg=FF at index 3 and at index 2, 99 at index 1, A4 at index 0. Assert rst_n low mid-scan → sel=1111, seg=FF immediately.
